// File: rtl/sram_pingpong_ctrl_pkg.sv
// Shared definitions for the ping-pong SRAM controller.
// Holds the per-bank state encoding, the default geometry (DEPTH/WIDTH/AW)
// and a small helper that says whether a bank holds data for the read side.
package sram_pingpong_ctrl_pkg;

    localparam int PP_DEPTH = 16;
    localparam int PP_WIDTH = 32;
    localparam int PP_AW    = 4;

    // Lifecycle of one bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY
    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_state_e;

    // A bank belongs to the read side once it is complete.
    function automatic logic bank_readable(input bank_state_e st);
        return (st == ST_FULL) || (st == ST_DRAINING);
    endfunction

    // A bank belongs to the write side until it is complete.
    function automatic logic bank_writable(input bank_state_e st);
        return (st == ST_EMPTY) || (st == ST_FILLING);
    endfunction

endpackage

// File: rtl/sram_pp_outfifo.sv
// Two-entry output FIFO for the ping-pong controller. Captures SRAM read data
// and presents the oldest word to the downstream valid/ready port. The head
// only changes on a pop, so the output is stable while stalled.
// Ports:
//   CLK, RESET_N - clock and asynchronous active-low reset
//   PUSH         - write PUSH_DATA this cycle (caller never pushes when full)
//   PUSH_DATA    - word captured from the SRAM Q bus
//   POP          - remove the head this cycle (caller only pops when valid)
//   HEAD_VALID   - FIFO holds at least one word
//   HEAD_DATA    - oldest word (0 after reset)
//   COUNT        - current occupancy, 0..2
module sram_pp_outfifo #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             PUSH,
    input  logic [WIDTH-1:0] PUSH_DATA,
    input  logic             POP,
    output logic             HEAD_VALID,
    output logic [WIDTH-1:0] HEAD_DATA,
    output logic [1:0]       COUNT
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;

    always_comb begin
        count_next = count_reg;
        case ({PUSH, POP})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (PUSH) begin
                mem_reg[wr_ptr_reg] <= PUSH_DATA;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (POP) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

    assign HEAD_VALID = (count_reg != 2'd0);
    assign HEAD_DATA  = mem_reg[rd_ptr_reg];
    assign COUNT      = count_reg;

endmodule

// File: rtl/sram_w16.sv
// Single-port synchronous SRAM macro model, 16 x 32 by default.
// Ports:
//   CLK  - clock, rising edge
//   CEN  - chip enable, active low
//   WEN  - write enable, active low (CEN=0, WEN=1 is a read)
//   A    - word address
//   D    - write data
//   Q    - read data, valid the cycle after a read access, held otherwise
module sram_w16 #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             CLK,
    input  logic             CEN,
    input  logic             WEN,
    input  logic [AW-1:0]    A,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!WEN) begin
                mem_reg[A] <= D;
            end else begin
                Q <= mem_reg[A];
            end
        end
    end

endmodule

// File: rtl/sram_pingpong_ctrl.sv
// Double-buffered (ping-pong) controller over two sram_w16 banks.
// One bank fills from the input stream while the other drains to the output
// stream, one word per cycle on each side. Banks are used 0,1,0,1... on both
// sides, so words leave in arrival order. A partially filled bank is held.
// Ports:
//   CLK, RESET_N        - clock and asynchronous active-low reset
//   IN_VALID/IN_READY   - input handshake, IN_DATA is the word
//   OUT_VALID/OUT_READY - output handshake, OUT_DATA is the word
//   BANK_FULL[b]        - bank b is FULL or DRAINING
module sram_pingpong_ctrl
    import sram_pingpong_ctrl_pkg::*;
#(
    parameter int DEPTH = PP_DEPTH,
    parameter int WIDTH = PP_WIDTH,
    parameter int AW    = PP_AW
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [1:0]       BANK_FULL
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    bank_state_e      state_reg  [2];
    bank_state_e      state_next [2];
    logic             wr_bank_reg;
    logic [AW-1:0]    wr_addr_reg;
    logic             rd_bank_reg;
    logic [AW-1:0]    rd_addr_reg;
    logic             inflight_reg;       // a read was issued last cycle
    logic             inflight_bank_reg;  // which bank that read targeted

    logic             wr_fire;
    logic             rd_issue;
    logic             pop;
    logic             wr_last;
    logic             rd_last;
    logic [1:0]       fifo_count;
    logic [2:0]       occupancy;
    logic [WIDTH-1:0] q_even;
    logic [WIDTH-1:0] q_odd;
    logic [WIDTH-1:0] push_data;

    logic [1:0]         bank_wr;
    logic [1:0]         bank_rd;
    logic [1:0]         bank_cen;
    logic [1:0]         bank_wen;
    logic [1:0][AW-1:0] bank_a;

    assign IN_READY = bank_writable(state_reg[wr_bank_reg]);
    assign wr_fire  = IN_VALID && IN_READY;
    assign pop      = OUT_VALID && OUT_READY;
    assign wr_last  = (wr_addr_reg == LAST_ADDR);
    assign rd_last  = (rd_addr_reg == LAST_ADDR);

    // Words already buffered plus the one coming back from the SRAM, less
    // the one leaving this cycle, must leave room for another read.
    assign occupancy = 3'(fifo_count) + 3'(inflight_reg) - 3'(pop);
    assign rd_issue  = bank_readable(state_reg[rd_bank_reg]) && (occupancy < 3'd2);

    // Write bank is EMPTY/FILLING and read bank is FULL/DRAINING, so the two
    // sides can never target the same bank in one cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign bank_wr[gi]   = wr_fire  && (wr_bank_reg == 1'(gi));
        assign bank_rd[gi]   = rd_issue && (rd_bank_reg == 1'(gi));
        assign bank_cen[gi]  = ~(bank_wr[gi] | bank_rd[gi]);
        assign bank_wen[gi]  = ~bank_wr[gi];
        assign bank_a[gi]    = bank_wr[gi] ? wr_addr_reg : rd_addr_reg;
        assign BANK_FULL[gi] = bank_readable(state_reg[gi]);
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_next[b] = state_reg[b];
            if (bank_wr[b]) begin
                state_next[b] = wr_last ? ST_FULL : ST_FILLING;
            end else if (bank_rd[b]) begin
                state_next[b] = rd_last ? ST_EMPTY : ST_DRAINING;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int b = 0; b < 2; b++) begin
                state_reg[b] <= ST_EMPTY;
            end
            wr_bank_reg       <= 1'b0;
            wr_addr_reg       <= '0;
            rd_bank_reg       <= 1'b0;
            rd_addr_reg       <= '0;
            inflight_reg      <= 1'b0;
            inflight_bank_reg <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_reg[b] <= state_next[b];
            end
            if (wr_fire) begin
                if (wr_last) begin
                    wr_addr_reg <= '0;
                    wr_bank_reg <= ~wr_bank_reg;
                end else begin
                    wr_addr_reg <= wr_addr_reg + 1'b1;
                end
            end
            if (rd_issue) begin
                if (rd_last) begin
                    rd_addr_reg <= '0;
                    rd_bank_reg <= ~rd_bank_reg;
                end else begin
                    rd_addr_reg <= rd_addr_reg + 1'b1;
                end
            end
            inflight_reg      <= rd_issue;
            inflight_bank_reg <= rd_bank_reg;
        end
    end

    sram_w16 #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) sram_even (
        .CLK (CLK),
        .CEN (bank_cen[0]),
        .WEN (bank_wen[0]),
        .A   (bank_a[0]),
        .D   (IN_DATA),
        .Q   (q_even)
    );

    sram_w16 #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) sram_odd (
        .CLK (CLK),
        .CEN (bank_cen[1]),
        .WEN (bank_wen[1]),
        .A   (bank_a[1]),
        .D   (IN_DATA),
        .Q   (q_odd)
    );

    assign push_data = inflight_bank_reg ? q_odd : q_even;

    sram_pp_outfifo #(.WIDTH(WIDTH)) u_outfifo (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .PUSH       (inflight_reg),
        .PUSH_DATA  (push_data),
        .POP        (pop),
        .HEAD_VALID (OUT_VALID),
        .HEAD_DATA  (OUT_DATA),
        .COUNT      (fifo_count)
    );

endmodule

// File: tb/tb_sram_pingpong_ctrl.sv
// Scoreboard bench for sram_pingpong_ctrl: accepted input words are queued,
// every output beat is popped and compared. Inputs change 1 time unit after
// the rising edge; outputs are observed on the falling edge.
module tb_sram_pingpong_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] IN_DATA = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] OUT_DATA;
    logic [1:0]  BANK_FULL;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_pop = 0;
    int          stall_cnt = 0;
    logic [31:0] exp_q [$];
    logic        hold_valid = 1'b0;
    logic [31:0] hold_data = '0;
    logic [1:0]  bf_prev = 2'b00;
    logic [7:0]  bank_log = '0;
    int          bank_cnt = 0;
    bit          rb_en = 1'b0;

    sram_pingpong_ctrl dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .BANK_FULL (BANK_FULL)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, required %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (!RESET_N) begin
            exp_q.delete();
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check_eq("out_hold", {31'd0, OUT_VALID, OUT_DATA}, {31'd0, 1'b1, hold_data});
            end
            if (IN_VALID && IN_READY) begin
                exp_q.push_back(IN_DATA);
            end
            if (OUT_VALID && OUT_READY) begin
                check_eq("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check_eq("out_data", 64'(OUT_DATA), 64'(e));
                    $display("cycle %0d: out %h expected %h", cyc, OUT_DATA, e);
                end
                n_pop++;
            end
            hold_valid = OUT_VALID && !OUT_READY;
            hold_data  = OUT_DATA;
        end
        for (int b = 0; b < 2; b++) begin
            if (BANK_FULL[b] && !bf_prev[b]) begin
                bank_log = {bank_log[6:0], 1'(b)};
                bank_cnt++;
            end
        end
        bf_prev = BANK_FULL;
    end

    // Random backpressure generator
    always @(posedge CLK) begin
        if (rb_en) begin
            #1;
            OUT_READY = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_reset();
        RESET_N   = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        @(negedge CLK);
        check_eq("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check_eq("rst_bank_full", 64'(BANK_FULL), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(negedge CLK);
        check_eq("rst_out_valid_rel", 64'(OUT_VALID), 64'd0);
        check_eq("rst_out_data", 64'(OUT_DATA), 64'd0);
        check_eq("rst_bank_full_rel", 64'(BANK_FULL), 64'd0);
        check_eq("rst_in_ready", 64'(IN_READY), 64'd1);
        n_pop     = 0;
        stall_cnt = 0;
        bank_cnt  = 0;
        bank_log  = '0;
        @(posedge CLK);
        #1;
    endtask

    // Offer one word; returns 1 time unit after the accepting edge.
    task automatic send_word(input logic [31:0] d);
        int t;
        bit acc;
        IN_VALID = 1'b1;
        IN_DATA  = d;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 2000) begin
            @(negedge CLK);
            acc = IN_READY;
            @(posedge CLK);
            #1;
            if (!acc) begin
                stall_cnt++;
                t++;
            end
        end
        check_eq("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_drain(input int expected_pops);
        int t;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while ((exp_q.size() != 0 || OUT_VALID) && t < 3000);
        check_eq("drain_done", 64'(exp_q.size() == 0 && !OUT_VALID), 64'd1);
        check_eq("pop_count", 64'(n_pop), 64'(expected_pops));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int e;
        int r;
        int t;
        bit seen;

        // ---- single bank ----
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 16; i++) send_word(32'hA000_0000 + 32'(i));
        IN_VALID = 1'b0;
        e = cyc;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (!OUT_VALID && t < 50);
        check_eq("fill_to_drain_lat", 64'(cyc - e), 64'd2);
        for (int i = 1; i < 16; i++) begin
            @(negedge CLK);
            check_eq("b2b_valid", 64'(OUT_VALID), 64'd1);
        end
        wait_drain(16);

        // ---- continuous stream ----
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 48; i++) send_word(32'hB000_0000 + 32'(i));
        IN_VALID = 1'b0;
        check_eq("stream_no_stall", 64'(stall_cnt), 64'd0);
        wait_drain(48);
        check_eq("bank_order", {56'(bank_cnt), 5'd0, bank_log[2:0]}, {56'd3, 5'd0, 3'b010});

        // ---- full stall ----
        do_reset();
        OUT_READY = 1'b0;
        for (int i = 0; i < 32; i++) send_word(32'hC000_0000 + 32'(i));
        IN_DATA = 32'hC000_0020;
        @(negedge CLK);
        check_eq("stall_in_ready", 64'(IN_READY), 64'd0);
        check_eq("stall_bank_full", 64'(BANK_FULL), 64'd3);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
        r = cyc;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (!IN_READY && t < 100);
        check_eq("ready_rise_cycle", 64'(cyc - r), 64'd14);
        wait_drain(32);

        // ---- random backpressure ----
        do_reset();
        rb_en = 1'b1;
        for (int i = 0; i < 64; i++) send_word(32'hD000_0000 + 32'(i) * 32'h0001_0003);
        IN_VALID = 1'b0;
        rb_en = 1'b0;
        @(posedge CLK);
        #2;
        OUT_READY = 1'b1;
        wait_drain(64);

        // ---- reset mid-fill ----
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 7; i++) send_word(32'hE000_0000 + 32'(i));
        IN_VALID = 1'b0;
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 16; i++) send_word(32'hF000_0000 + 32'(i));
        IN_VALID = 1'b0;
        wait_drain(16);

        // ---- partial bank ----
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 15; i++) send_word(32'h1234_0000 + 32'(i));
        IN_VALID = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(negedge CLK);
            if (OUT_VALID) seen = 1'b1;
        end
        check_eq("partial_no_out", 64'(seen), 64'd0);
        check_eq("partial_bank_full", 64'(BANK_FULL), 64'd0);
        check_eq("partial_in_ready", 64'(IN_READY), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
